// File: rtl/sift_pkg.sv
// sift_pkg: shared constants and types for the SIFT front-end stages.
//   GRAD_BIT_DEPTH    - signed gradient sample width
//   IMG_WIDTH/HEIGHT  - default frame geometry
//   BRAM_READ_LATENCY - read latency of the gradient BRAMs (output register on)
//   grad_beat_t       - one (addr, x, y, last) gradient beat at default geometry
//   rd_state_e        - gradient_bram_reader sequencer states
package sift_pkg;

    localparam int GRAD_BIT_DEPTH    = 8;
    localparam int IMG_WIDTH         = 64;
    localparam int IMG_HEIGHT        = 64;
    localparam int BRAM_READ_LATENCY = 2;
    localparam int IMG_ADDR_W        = $clog2(IMG_WIDTH * IMG_HEIGHT);

    typedef struct packed {
        logic [IMG_ADDR_W-1:0]     addr;
        logic [GRAD_BIT_DEPTH-1:0] x;
        logic [GRAD_BIT_DEPTH-1:0] y;
        logic                      last;
    } grad_beat_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-high reset.
//   clk_in, rst_in   - clock and synchronous reset (clears pointers and count)
//   push, wr_data    - write strobe and data (ignored when full unless popping)
//   pop, rd_data     - read strobe and head data (rd_data is the current head)
//   count            - number of stored entries, 0..DEPTH
//   empty, full      - occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = count_q[PW];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        // Storage is never reset; only entries below count_q are ever observed.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/gradient_bram_reader.sv
// gradient_bram_reader: drains the x/y gradient BRAMs as one valid/ready stream
// of (addr, x, y, last) beats after a start pulse.
//   clk_in, rst_in        - clock, synchronous active-high reset
//   start_in              - one-cycle pulse starting a full-frame drain (IDLE only)
//   read_addr/_valid      - shared address and enable for both gradient BRAMs
//   x_pixel_in/y_pixel_in - BRAM read data, valid BRAM_READ_LATENCY cycles after issue
//   out_valid/out_ready   - output handshake; out_* held while stalled
//   out_addr/x/y/last     - beat payload; last marks pixel WIDTH*HEIGHT-1
//   busy_out, done_out    - frame in progress; one-cycle completion pulse
// Build option GRADIENT_BORDER_ZERO_EN: beats on the image border carry x=y=0.
//
// state    | meaning
// RD_IDLE  | waiting for start_in
// RD_READ  | issuing reads, credit-limited by FIFO occupancy plus in-flight reads
// RD_DRAIN | all reads issued; waiting for BRAM pipe and FIFO to empty
// RD_DONE  | one-cycle done_out pulse
module gradient_bram_reader
    import sift_pkg::*;
#(
    parameter int BIT_DEPTH  = GRAD_BIT_DEPTH,
    parameter int WIDTH      = IMG_WIDTH,
    parameter int HEIGHT     = IMG_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   read_addr,
    output logic                              read_addr_valid,
    input  logic [BIT_DEPTH-1:0]              x_pixel_in,
    input  logic [BIT_DEPTH-1:0]              y_pixel_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   out_addr,
    output logic [BIT_DEPTH-1:0]              out_x,
    output logic [BIT_DEPTH-1:0]              out_y,
    output logic                              out_last,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int N   = WIDTH * HEIGHT;
    localparam int AW  = $clog2(N);
    localparam int LAT = BRAM_READ_LATENCY;
    localparam int IW  = $clog2(LAT + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int OW  = CW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef struct packed {
        logic [AW-1:0]        addr;
        logic [BIT_DEPTH-1:0] x;
        logic [BIT_DEPTH-1:0] y;
        logic                 last;
    } beat_t;

    rd_state_e     state_q, state_d;
    logic [AW-1:0] issue_addr_q, issue_addr_d;
    logic [LAT-1:0] pipe_v_q, pipe_v_d;
    logic [AW-1:0] pipe_a_q [LAT];
    logic [AW-1:0] pipe_a_d [LAT];

    logic [IW-1:0] inflight;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    logic          issue, push, pop, drain_done;
    logic [AW-1:0] cap_addr;
    logic [BIT_DEPTH-1:0] cap_x, cap_y;
    beat_t         push_beat, head_beat;

    // Reads in the BRAM pipe already own a FIFO slot, so the pipe never stalls.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + IW'(pipe_v_q[i]);
        end
    end

    assign occupancy  = OW'(fifo_count) + OW'(inflight);
    assign pop        = out_valid && out_ready;
    assign push       = pipe_v_q[LAT-1];
    assign cap_addr   = pipe_a_q[LAT-1];
    // Leave DRAIN in the cycle the final beat is accepted so done follows it directly.
    assign drain_done = (inflight == '0) &&
                        (fifo_empty || ((fifo_count == CW'(1)) && pop));

    always_comb begin
        state_d      = state_q;
        issue_addr_d = issue_addr_q;
        issue        = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (start_in) begin
                    state_d      = RD_READ;
                    issue_addr_d = '0;
                end
            end
            RD_READ: begin
                if ((occupancy < OW'(FIFO_DEPTH)) && !fifo_full) begin
                    issue = 1'b1;
                    if (issue_addr_q == LAST_ADDR) begin
                        state_d      = RD_DRAIN;
                        issue_addr_d = '0;
                    end else begin
                        issue_addr_d = issue_addr_q + 1'b1;
                    end
                end
            end
            RD_DRAIN: begin
                if (drain_done) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_v_d    = {pipe_v_q[LAT-2:0], issue};
        pipe_a_d    = pipe_a_q;
        pipe_a_d[0] = issue_addr_q;
        for (int i = 1; i < LAT; i++) begin
            pipe_a_d[i] = pipe_a_q[i-1];
        end
    end

`ifdef GRADIENT_BORDER_ZERO_EN
    logic [AW-1:0] cap_col, cap_row;
    logic          on_border;

    always_comb begin
        cap_col   = cap_addr % AW'(WIDTH);
        cap_row   = cap_addr / AW'(WIDTH);
        on_border = (cap_col == '0) || (cap_col == AW'(WIDTH - 1)) ||
                    (cap_row == '0) || (cap_row == AW'(HEIGHT - 1));
        cap_x     = on_border ? '0 : x_pixel_in;
        cap_y     = on_border ? '0 : y_pixel_in;
    end
`else
    assign cap_x = x_pixel_in;
    assign cap_y = y_pixel_in;
`endif

    assign push_beat = '{addr: cap_addr, x: cap_x, y: cap_y, last: (cap_addr == LAST_ADDR)};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= RD_IDLE;
            issue_addr_q <= '0;
            pipe_v_q     <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_a_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            issue_addr_q <= issue_addr_d;
            pipe_v_q     <= pipe_v_d;
            pipe_a_q     <= pipe_a_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (push),
        .wr_data (push_beat),
        .pop     (pop),
        .rd_data (head_beat),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign read_addr       = issue_addr_q;
    assign read_addr_valid = issue;
    assign out_valid       = !fifo_empty;
    // Unwritten FIFO storage is never exposed: payload reads as zero when empty.
    assign out_addr        = out_valid ? head_beat.addr : '0;
    assign out_x           = out_valid ? head_beat.x    : '0;
    assign out_y           = out_valid ? head_beat.y    : '0;
    assign out_last        = out_valid && head_beat.last;
    assign busy_out        = (state_q != RD_IDLE);
    assign done_out        = (state_q == RD_DONE);

endmodule

// File: tb/tb_gradient_bram_reader.sv
// Bench for gradient_bram_reader: BRAM model with 2-cycle latency, scoreboard
// filled when a start is issued, monitor on the falling edge.
module tb_gradient_bram_reader;

    localparam int BD    = 8;
    localparam int W     = 64;
    localparam int H     = 64;
    localparam int N     = W * H;
    localparam int AW    = $clog2(N);
    localparam int BW    = AW + 2 * BD + 1;
    localparam int DEPTH = 4;

    logic          clk_in    = 1'b0;
    logic          rst_in    = 1'b1;
    logic          start_in  = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] read_addr;
    logic          read_addr_valid;
    logic [BD-1:0] x_pixel_in = '0;
    logic [BD-1:0] y_pixel_in = '0;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [BD-1:0] out_x, out_y;
    logic          out_last, busy_out, done_out;

    int n_checks    = 0;
    int n_fail      = 0;
    int frames_done = 0;
    bit full_rate   = 1'b0;
    bit bp_mode     = 1'b0;

    always #5 clk_in = ~clk_in;

    gradient_bram_reader #(
        .BIT_DEPTH  (BD),
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .read_addr       (read_addr),
        .read_addr_valid (read_addr_valid),
        .x_pixel_in      (x_pixel_in),
        .y_pixel_in      (y_pixel_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_last        (out_last),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    function automatic logic [BD-1:0] bram_x(input logic [AW-1:0] a);
`ifdef GRADIENT_BORDER_ZERO_EN
        return (a[0] & 1'b0) ? 8'h00 : 8'h7F;
`else
        return a[BD-1:0];
`endif
    endfunction

    function automatic logic [BD-1:0] bram_y(input logic [AW-1:0] a);
`ifdef GRADIENT_BORDER_ZERO_EN
        return (a[0] & 1'b0) ? 8'h00 : 8'h7F;
`else
        return ~a[BD-1:0];
`endif
    endfunction

    // Expected beat for pixel i, worked out from the image geometry.
    function automatic logic [BW-1:0] exp_beat(input int i);
        logic [AW-1:0] a;
        logic [BD-1:0] x, y;
        a = AW'(i);
        x = bram_x(a);
        y = bram_y(a);
`ifdef GRADIENT_BORDER_ZERO_EN
        if ((i % W == 0) || (i % W == W - 1) || (i / W == 0) || (i / W == H - 1)) begin
            x = '0;
            y = '0;
        end
`endif
        return {a, x, y, (i == N - 1)};
    endfunction

    // Two-stage BRAM: address register, then output register.
    logic [AW-1:0] bram_addr_q = '0;
    always @(posedge clk_in) begin
        if (read_addr_valid) bram_addr_q <= read_addr;
        x_pixel_in <= bram_x(bram_addr_q);
        y_pixel_in <= bram_y(bram_addr_q);
    end

    // ---------------- scoreboard / monitor ----------------
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] cur_beat, prev_beat, e;
    int rel = 0, issued = 0, accepted = 0, exp_rd = 0;
    int first_rel = -1, last_rel = -1, done_rel = -1;
    bit active = 1'b0, rst_prev = 1'b0, stall_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d of frame)", name, act, req, rel);
        end
    endtask

    always @(negedge clk_in) begin
        cur_beat = {out_addr, out_x, out_y, out_last};
        if (rst_prev) begin
            chk("reset read_addr",       32'(read_addr),       32'd0);
            chk("reset read_addr_valid", 32'(read_addr_valid), 32'd0);
            chk("reset out_valid",       32'(out_valid),       32'd0);
            chk("reset out_addr",        32'(out_addr),        32'd0);
            chk("reset out_x",           32'(out_x),           32'd0);
            chk("reset out_y",           32'(out_y),           32'd0);
            chk("reset out_last",        32'(out_last),        32'd0);
            chk("reset busy_out",        32'(busy_out),        32'd0);
            chk("reset done_out",        32'(done_out),        32'd0);
        end
        rst_prev = rst_in;
        if (rst_in) begin
            exp_q.delete();
            active     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (active) rel++;
            if (start_in && !active) begin
                active    = 1'b1;
                rel       = 0;
                issued    = 0;
                accepted  = 0;
                exp_rd    = 0;
                first_rel = -1;
                last_rel  = -1;
                done_rel  = -1;
                for (int i = 0; i < N; i++) exp_q.push_back(exp_beat(i));
            end
            if (active && rel == 1) begin
                chk("cycle1 busy_out",        32'(busy_out),        32'd1);
                chk("cycle1 read_addr_valid", 32'(read_addr_valid), 32'd1);
                chk("cycle1 read_addr",       32'(read_addr),       32'd0);
            end
            if (read_addr_valid) begin
                chk("issue within credit", 32'((issued - accepted) < DEPTH), 32'd1);
                chk("issue address",       32'(read_addr),                   32'(exp_rd));
                issued++;
                exp_rd++;
            end
            if (bp_mode && active && rel == 21) begin
                chk("reads issued under backpressure", 32'(issued),    32'd4);
                chk("stalled out_valid",               32'(out_valid), 32'd1);
                chk("stalled out_addr",                32'(out_addr),  32'd0);
            end
            if (stall_prev) begin
                chk("stall out_valid held", 32'(out_valid), 32'd1);
                chk("stall beat stable",    32'(cur_beat),  32'(prev_beat));
            end
            if (active && out_valid && first_rel < 0) begin
                first_rel = rel;
                chk("first beat cycle", 32'(rel), 32'd4);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected beat: got addr 0x%0h, required no beat", out_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat {addr,x,y,last}", 32'(cur_beat), 32'(e));
                    if (e[0]) last_rel = rel;
                end
                accepted++;
            end
            if (done_out) begin
                if (!active) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious done_out: got 1, required 0");
                end else begin
                    chk("done one cycle after last accept", 32'(rel), 32'(last_rel + 1));
                    chk("scoreboard empty at done", 32'(exp_q.size()), 32'd0);
                    if (full_rate) begin
                        chk("last beat cycle", 32'(last_rel), 32'(N + 3));
                        chk("done cycle",      32'(rel),      32'(N + 4));
                    end
                    done_rel = rel;
                    frames_done++;
                end
            end
            if (active && done_rel >= 0 && rel == done_rel + 1) begin
                chk("busy low after done", 32'(busy_out), 32'd0);
                active = 1'b0;
            end
            if (active && done_rel < 0 && rel > 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame completion: got no done_out by cycle %0d, required done", rel);
                active = 1'b0;
                exp_q.delete();
                frames_done++;
            end
            stall_prev = out_valid && !out_ready;
            prev_beat  = cur_beat;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
    endtask

    task automatic wait_frame(input bit rnd, input int base);
        int i;
        i = 0;
        while (frames_done == base && i < 30000) begin
            @(posedge clk_in); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            i++;
        end
        if (frames_done == base) begin
            $display("FAIL frame wait: got no done_out in 30000 cycles, required done");
            $fatal(1, "bench stopped");
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    initial begin
        int base;
        int seeds[3] = '{11, 22, 33};
        repeat (4) @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;

        // full-rate ramp frame
        full_rate = 1'b1;
        base = frames_done;
        pulse_start();
        wait_frame(1'b0, base);
        full_rate = 1'b0;

        // out_ready low for cycles 2..21
        bp_mode = 1'b1;
        base = frames_done;
        pulse_start();
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        repeat (20) @(posedge clk_in);
        #1 out_ready = 1'b1;
        wait_frame(1'b0, base);
        bp_mode = 1'b0;

        // random backpressure, three seeds
        foreach (seeds[k]) begin
            void'($urandom(seeds[k]));
            base = frames_done;
            pulse_start();
            wait_frame(1'b1, base);
        end

        // reset at cycle 100, restart at cycle 105
        pulse_start();
        repeat (99) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        base = frames_done;
        pulse_start();
        wait_frame(1'b0, base);

        // start pulsed again at cycle 50 while busy
        base = frames_done;
        pulse_start();
        repeat (49) @(posedge clk_in);
        #1 start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        wait_frame(1'b0, base);

        repeat (20) @(posedge clk_in);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
